serializador: RTL and testbench

SERIALIZADOR -- requirements
Module: serializador

---
 rtl/serializador_pkg.sv | 16 +
 rtl/serializador_if.sv | 21 ++
 rtl/ser_contador.sv | 24 ++
 rtl/serializador.sv | 116 +++++++++++
 tb/tb_serializador.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serializador_pkg.sv
// Shared types and constants for the byte serializer.
// Imported by the interface, counter and top.
package serializador_pkg;

  localparam int FRAME_BITS = 8;
  localparam int BIT_CNT_W = 3;
  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    WAIT_ACK
  } ser_state_t;

endpackage

// File: rtl/serializador_if.sv
// Parallel byte valid/ready handshake
// into the serializer.
interface serializador_if;
  import serializador_pkg::*;

  logic [FRAME_BITS-1:0] byte_in;
  logic                  byte_valid_in;
  logic                  byte_ready_out;

  modport master (
    output byte_in,
    output byte_valid_in,
    input  byte_ready_out
  );

  modport slave (
    input  byte_in,
    input  byte_valid_in,
    output byte_ready_out
  );
endinterface

// File: rtl/ser_contador.sv
// Load/decrement down-counter shared by the
// bit count and the gap count.
module ser_contador #(
  parameter int W = 4
) (
  input  logic         clk_100KHz,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk_100KHz) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/serializador.sv
// Byte-to-serial transmitter: 8 strobed bits,
// optional idle gap, then wait for downstream ack.
module serializador
  import serializador_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic           clk_100KHz,
  input  logic           reset,
  serializador_if.slave  bus,
  input  logic           status_in,
  output logic           data_out,
  output logic           write_out,
  output logic           busy_out,
  output logic [7:0]     bytes_sent_out
);

  localparam logic [BIT_CNT_W-1:0] BIT_LOAD =
    BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
    GAP_CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  ser_state_t state, state_n;

  logic [FRAME_BITS-1:0] sr;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [GAP_CNT_W-1:0]  gap_cnt;
  logic accept;
  logic bit_load, bit_dec;
  logic gap_load, gap_dec;
  logic last_bit;

  assign bus.byte_ready_out =
    (state == IDLE) && !status_in;
  assign accept =
    bus.byte_valid_in && bus.byte_ready_out;
  assign last_bit = (bit_cnt == '0);
  assign busy_out = (state != IDLE);

  always_comb begin
    state_n   = state;
    bit_load  = 1'b0;
    bit_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    write_out = 1'b0;
    data_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n  = SHIFT;
          bit_load = 1'b1;
        end
      end
      SHIFT: begin
        write_out = 1'b1;
        data_out  = (MSB_FIRST != 0) ?
                    sr[FRAME_BITS-1] : sr[0];
        if (last_bit) begin
          state_n  = (GAP_CYCLES == 0) ?
                     WAIT_ACK : GAP;
          gap_load = 1'b1;
        end else begin
          bit_dec = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = WAIT_ACK;
        else gap_dec = 1'b1;
      end
      WAIT_ACK: begin
        if (!status_in) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_100KHz) begin
    if (!reset) begin
      state          <= IDLE;
      sr             <= '0;
      bytes_sent_out <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        sr <= bus.byte_in;
      end else if (state == SHIFT) begin
        sr <= (MSB_FIRST != 0) ?
              {sr[FRAME_BITS-2:0], 1'b0} :
              {1'b0, sr[FRAME_BITS-1:1]};
      end
      if (state == SHIFT && last_bit)
        bytes_sent_out <= bytes_sent_out + 8'd1;
    end
  end

  ser_contador #(.W(BIT_CNT_W)) u_bit (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .load       (bit_load),
    .load_val   (BIT_LOAD),
    .dec        (bit_dec),
    .count      (bit_cnt)
  );

  ser_contador #(.W(GAP_CNT_W)) u_gap (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .load       (gap_load),
    .load_val   (GAP_LOAD),
    .dec        (gap_dec),
    .count      (gap_cnt)
  );

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: default instance and an
// LSB-first, no-gap instance against a timeline model.
module tb_serializador;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       status;
  logic [7:0] v_byte;
  logic       v_valid;

  serializador_if if0();
  serializador_if if1();

  assign if0.byte_in       = v_byte;
  assign if0.byte_valid_in = v_valid;
  assign if1.byte_in       = v_byte;
  assign if1.byte_valid_in = v_valid;

  logic       d0, w0, b0, d1, w1, b1;
  logic [7:0] c0, c1;

  serializador u0 (
    .clk_100KHz     (clk),
    .reset          (rst_n),
    .bus            (if0),
    .status_in      (status),
    .data_out       (d0),
    .write_out      (w0),
    .busy_out       (b0),
    .bytes_sent_out (c0)
  );

  serializador #(
    .GAP_CYCLES (0),
    .MSB_FIRST  (0)
  ) u1 (
    .clk_100KHz     (clk),
    .reset          (rst_n),
    .bus            (if1),
    .status_in      (status),
    .data_out       (d1),
    .write_out      (w1),
    .busy_out       (b1),
    .bytes_sent_out (c1)
  );

  int checks = 0;
  int errors = 0;

  // Model: pos = cycles since acceptance, 0 = idle.
  int         pos  [2];
  logic [7:0] mbyte[2];
  logic [7:0] mcnt [2];
  // {ready, busy, write, data, count[7:0]}
  logic [11:0] cap [2];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int gap_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [11:0] exp_out(int k);
    logic wr, dd;
    wr = 1'b0;
    dd = 1'b0;
    if (pos[k] >= 1 && pos[k] <= 8) begin
      wr = 1'b1;
      if (k == 0) dd = mbyte[k][8 - pos[k]];
      else        dd = mbyte[k][pos[k] - 1];
    end
    return {(pos[k] == 0) && !status, pos[k] != 0,
            wr, dd, mcnt[k]};
  endfunction

  function automatic logic [11:0] act_out(int k);
    if (k == 0) return {if0.byte_ready_out, b0, w0, d0, c0};
    return {if1.byte_ready_out, b1, w1, d1, c1};
  endfunction

  task automatic model_edge(int k);
    int g;
    g = gap_of(k);
    if (!rst_n) begin
      pos[k]  = 0;
      mcnt[k] = 8'd0;
    end else if (pos[k] == 0) begin
      if (v_valid && !status) begin
        pos[k]   = 1;
        mbyte[k] = v_byte;
      end
    end else if (pos[k] < 9 + g) begin
      if (pos[k] == 8) mcnt[k] = mcnt[k] + 8'd1;
      pos[k]++;
    end else if (!status) begin
      pos[k] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      cap[k] = act_out(k);
      check($sformatf("dut%0d_outputs", k),
            32'(cap[k]), 32'(exp_out(k)));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cap[0][10] || cap[1][10]) && n < 40) begin
      cycle();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy want idle");
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] ms;
    logic [7:0] ls;
  } vec_t;
  vec_t tbl[5];

  initial begin
    logic [7:0] s0, s1;
    int n0, n1, ok, ns, low, frames;
    int starts[2];
    logic prev;
    logic [7:0] pc;

    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'hF0, 8'hF0, 8'h0F};
    tbl[3] = '{8'h3C, 8'h3C, 8'h3C};
    tbl[4] = '{8'hC1, 8'hC1, 8'h83};

    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; mbyte[k] = 8'd0; mcnt[k] = 8'd0;
    end
    rst_n = 1'b0; status = 1'b0;
    v_byte = 8'd0; v_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    cycle();
    check("reset_state", 32'(cap[0]), 32'h800);
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 5; i++) begin
      wait_idle();
      v_byte = tbl[i].b; v_valid = 1'b1;
      cycle();
      v_valid = 1'b0;
      s0 = 8'd0; s1 = 8'd0; n0 = 0; n1 = 0;
      for (int j = 0; j < 8; j++) begin
        cycle();
        s0 = {s0[6:0], cap[0][8]};
        s1 = {s1[6:0], cap[1][8]};
        n0 += int'(cap[0][9]);
        n1 += int'(cap[1][9]);
      end
      cycle();
      n0 += int'(cap[0][9]);
      n1 += int'(cap[1][9]);
      check($sformatf("msb_stream_%0d", i), 32'(s0), 32'(tbl[i].ms));
      check($sformatf("lsb_stream_%0d", i), 32'(s1), 32'(tbl[i].ls));
      check($sformatf("frame_len0_%0d", i), n0, 8);
      check($sformatf("frame_len1_%0d", i), n1, 8);
      check($sformatf("sent0_%0d", i), 32'(cap[0][7:0]), i + 1);
    end

    wait_idle();
    v_byte = 8'h5A; v_valid = 1'b1;
    cycle();
    v_valid = 1'b0;
    cycle(); cycle();
    status = 1'b1;
    repeat (10) cycle();
    ok = 0;
    repeat (20) begin
      cycle();
      if (cap[0][10] && !cap[0][11]) ok++;
    end
    check("wait_ack_hold", ok, 20);
    status = 1'b0;
    cycle();
    cycle();
    check("ack_release", 32'(cap[0][11:10]), 32'b10);

    wait_idle();
    v_valid = 1'b1; v_byte = 8'h01;
    prev = 1'b0; ns = 0; low = 0;
    starts[0] = 0; starts[1] = 0;
    for (int t = 0; t < 40; t++) begin
      cycle();
      if (cap[0][9] && !prev && ns < 2) begin
        starts[ns] = t;
        ns++;
      end
      if (ns == 1) begin
        v_byte = 8'h02;
        if (!cap[0][9]) low++;
      end
      prev = cap[0][9];
    end
    v_valid = 1'b0;
    check("stream_starts", ns, 2);
    check("stream_period", starts[1] - starts[0], 12);
    check("stream_low_gap", low, 4);

    wait_idle();
    v_byte = 8'hFF; v_valid = 1'b1;
    cycle();
    v_valid = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    check("rst_mid_was_shift", 32'(cap[0][9]), 1);
    rst_n = 1'b1;
    cycle();
    check("rst_mid_u0", 32'(cap[0][10:0]), 32'h0);
    check("rst_mid_u1", 32'(cap[1][10:0]), 32'h0);

    v_valid = 1'b1;
    frames = 0;
    pc = cap[0][7:0];
    for (int t = 0; t < 3300 && frames < 256; t++) begin
      v_byte = 8'($urandom);
      cycle();
      if (cap[0][7:0] != pc) frames++;
      pc = cap[0][7:0];
    end
    v_valid = 1'b0;
    check("wrap_frames", frames, 256);
    check("wrap_count", 32'(cap[0][7:0]), 32'h0);

    for (int t = 0; t < 3000; t++) begin
      v_valid = 1'($urandom_range(0, 1));
      v_byte  = 8'($urandom);
      status  = ($urandom_range(0, 3) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
